// File: rtl/gen_parity_acc_if.sv
// Handshake bundle for gen_parity_acc: operand input stream and parity/checksum output stream.
interface gen_parity_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_last;
    logic [WIDTH-1:0] out_acc;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, out_y, out_last, out_acc
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, out_y, out_last, out_acc
    );
endinterface

// File: rtl/gen_parity_acc.sv
// Two-stage per-lane tapped-XOR parity pipe with optional frame checksum.
// Frame counter / accumulator / out_last / out_acc exist only under GEN_PARITY_FRAME_ACC_EN.
module gen_parity_lane #(
    parameter int TAPS = 5,
    parameter bit EVEN = 1'b1
) (
    input  logic            a,
    input  logic            b,
    input  logic [TAPS-1:0] taps,
    output logic            m_lo,
    output logic            m_hi,
    output logic            y
);
    assign m_lo = EVEN ? (a & b) : (a | b);
    assign m_hi = EVEN ? (a | b) : (a & b);
    assign y    = ^taps;
endmodule

module gen_parity_acc #(
    parameter int WIDTH     = 8,
    parameter int TAPS      = 5,
    parameter int STRIDE    = 2,
    parameter int FRAME_LEN = 4
) (
    input  logic            clk,
    input  logic            rst,
    gen_parity_acc_if.slave bus
);
    localparam int MW     = 2 * WIDTH;
    // vld_pipe[0] is the mix stage, vld_pipe[STAGES] drives out_valid
    localparam int STAGES = 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    req_t              req;
    logic [STAGES:0]   vld_pipe;
    logic [MW-1:0]     m_d;
    logic [MW-1:0]     m_q;
    logic [WIDTH-1:0]  y_d;
    logic [WIDTH-1:0]  y_q;
    logic              adv;

    assign req = '{a: bus.a, b: bus.b};
    assign adv = !vld_pipe[STAGES] || bus.out_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [TAPS-1:0] taps;
        for (genvar j = 0; j < TAPS; j++) begin : g_tap
            assign taps[j] = m_q[(i + STRIDE * j) % MW];
        end
        gen_parity_lane #(
            .TAPS (TAPS),
            .EVEN ((i % 2) == 0)
        ) u_lane (
            .a    (req.a[i]),
            .b    (req.b[i]),
            .taps (taps),
            .m_lo (m_d[i]),
            .m_hi (m_d[i + WIDTH]),
            .y    (y_d[i])
        );
    end

    // Global stall: both stages move together only when the output slot frees up
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            m_q      <= '0;
            y_q      <= '0;
        end else if (adv) begin
            vld_pipe <= {vld_pipe[STAGES-1:0], bus.in_valid};
            if (bus.in_valid) m_q <= m_d;
            if (vld_pipe[0])  y_q <= y_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_pipe[STAGES];
    assign bus.out_y     = y_q;

`ifdef GEN_PARITY_FRAME_ACC_EN
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    logic [CW-1:0]    beat_cnt;
    logic [WIDTH-1:0] run_acc;
    logic             xfer;
    logic             last_beat;

    assign xfer      = vld_pipe[STAGES] && bus.out_ready;
    assign last_beat = (beat_cnt == CW'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            run_acc  <= '0;
        end else if (xfer) begin
            if (last_beat) begin
                beat_cnt <= '0;
                run_acc  <= '0;
            end else begin
                beat_cnt <= beat_cnt + CW'(1);
                run_acc  <= run_acc ^ y_q;
            end
        end
    end

    // Accumulator includes the beat currently on out_y, so it is complete on the last beat
    assign bus.out_last = vld_pipe[STAGES] && last_beat;
    assign bus.out_acc  = run_acc ^ y_q;
`else
    assign bus.out_last = 1'b0;
    assign bus.out_acc  = '0;
`endif
endmodule

// File: tb/tb_gen_parity_acc.sv
// Directed + random bench for gen_parity_acc; scoreboard of expected parity words and frame model.
module tb_gen_parity_acc;
    localparam int W    = 8;
    localparam int TAPS = 5;
    localparam int FL   = 4;
`ifdef GEN_PARITY_FRAME_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gen_parity_acc_if #(.WIDTH(W)) if0 ();
    gen_parity_acc_if #(.WIDTH(W)) if1 ();

    gen_parity_acc #(.WIDTH(W), .TAPS(TAPS), .STRIDE(2), .FRAME_LEN(FL)) u0 (
        .clk (clk), .rst (rst), .bus (if0.slave));
    gen_parity_acc #(.WIDTH(W), .TAPS(TAPS), .STRIDE(3), .FRAME_LEN(FL)) u1 (
        .clk (clk), .rst (rst), .bus (if1.slave));

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] exp_q[$];
    int           fbeat;
    logic [W-1:0] facc;
    int           n_xfer;
    int           last_at;

    logic         ov, olast, ir;
    logic [W-1:0] oy, oacc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Spec-level model: build the mix vector, then XOR TAPS wrapped indices per lane
    function automatic logic [W-1:0] ref_y(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int stride);
        logic [2*W-1:0] m;
        logic [W-1:0]   y;
        for (int i = 0; i < W; i++) begin
            if (i % 2 == 0) begin
                m[i] = a[i] & b[i]; m[i+W] = a[i] | b[i];
            end else begin
                m[i] = a[i] | b[i]; m[i+W] = a[i] & b[i];
            end
        end
        for (int i = 0; i < W; i++) begin
            y[i] = 1'b0;
            for (int j = 0; j < TAPS; j++) y[i] = y[i] ^ m[(i + stride * j) % (2 * W)];
        end
        return y;
    endfunction

    task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ordy);
        logic [W-1:0] e;
        @(negedge clk);
        if0.in_valid  = iv;
        if0.a         = ia;
        if0.b         = ib;
        if0.out_ready = ordy;
        #1;
        ov = if0.out_valid; oy = if0.out_y; olast = if0.out_last; oacc = if0.out_acc;
        ir = if0.in_ready;
        chk("in_ready", ir, !ov || ordy);
        if (ov) begin
            chk("q_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                chk("out_y", oy, e);
                chk("out_last", olast, ACC_EN ? (fbeat == FL - 1) : 1'b0);
                chk("out_acc", oacc, ACC_EN ? (facc ^ e) : '0);
                if (ordy) begin
                    void'(exp_q.pop_front());
                    n_xfer++;
                    if (olast) last_at = n_xfer;
                    if (fbeat == FL - 1) begin fbeat = 0; facc = '0; end
                    else begin fbeat++; facc = facc ^ e; end
                end
            end
        end else begin
            chk("idle_last", olast, 0);
        end
        if (iv && ir) exp_q.push_back(ref_y(ia, ib, 2));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        if0.in_valid = 1'b1; if0.a = 8'hFF; if0.b = 8'h00; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if0.in_valid = 1'b0;
        #1;
        exp_q.delete();
        fbeat = 0; facc = '0;
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_in_ready", if0.in_ready, 1);
        chk("rst_out_y", if0.out_y, 0);
        chk("rst_out_last", if0.out_last, 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (exp_q.size() != 0 || ov); k++) step(1'b0, '0, '0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, sa, sb;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.out_ready = 1'b1;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.out_ready = 1'b1;
        fbeat = 0; facc = '0; n_xfer = 0; last_at = 0;
        ov = 1'b0;
        do_reset();

        // Latency and first frame 99, FF, 00, FF
        step(1'b1, 8'hFF, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        chk("lat_c1_valid", ov, 0);
        step(1'b1, 8'h00, 8'h00, 1'b1);
        chk("lat_c2_valid", ov, 1);
        chk("lat_c2_y", oy, 8'h99);
        step(1'b1, 8'hFF, 8'hFF, 1'b1);
        chk("ones_y", oy, 8'hFF);
        step(1'b0, '0, '0, 1'b1);
        chk("zeros_y", oy, 8'h00);
        step(1'b0, '0, '0, 1'b1);
        chk("frame_y4", oy, 8'hFF);
        chk("frame_last4", olast, ACC_EN);
        chk("frame_acc4", oacc, ACC_EN ? 8'h99 : 8'h00);
        // Second frame restarts its count
        for (int k = 0; k < FL; k++) step(1'b1, W'($urandom), W'($urandom), 1'b1);
        drain();

        // Stall with full pipe for 5 cycles
        sa = W'($urandom); sb = W'($urandom);
        step(1'b1, sa, sb, 1'b0);
        step(1'b1, W'($urandom), W'($urandom), 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, W'($urandom), W'($urandom), 1'b0);
            chk("stall_in_ready", ir, 0);
            chk("stall_hold", oy, ref_y(sa, sb, 2));
        end
        for (int k = 0; k < 10; k++) step(1'b1, W'($urandom), W'($urandom), 1'b1);
        drain();

        // Random traffic with backpressure
        for (int k = 0; k < 300; k++) begin
            ra = W'($urandom); rb = W'($urandom);
            step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0);
        end
        drain();

        // Tap wrap on the STRIDE=3 instance
        @(negedge clk);
        if1.in_valid = 1'b1; if1.a = 8'h08; if1.b = 8'h08; if1.out_ready = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        #1;
        chk("s3_c1_valid", if1.out_valid, 0);
        @(negedge clk);
        #1;
        chk("s3_valid", if1.out_valid, 1);
        chk("s3_y", if1.out_y, 8'hAD);
        chk("s3_model", if1.out_y, ref_y(8'h08, 8'h08, 3));

        // Reset mid-frame with two beats in flight
        do_reset();
        step(1'b1, W'($urandom), W'($urandom), 1'b1);
        step(1'b1, W'($urandom), W'($urandom), 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        step(1'b1, W'($urandom), W'($urandom), 1'b1);
        step(1'b1, W'($urandom), W'($urandom), 1'b0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b0, '0, '0, 1'b1);
            chk("rst_flush_valid", ov, 0);
        end
        n_xfer = 0; last_at = 0;
        for (int k = 0; k < FL; k++) step(1'b1, W'($urandom), W'($urandom), 1'b1);
        drain();
        chk("rst_frame_last_at", last_at, ACC_EN ? FL : 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/gen_parity_acc.md
GEN_PARITY_ACC -- requirements
Module: gen_parity_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, lane count (>=1).
REQ-002 SHALL have parameter TAPS, default 5, XOR taps per lane (1..2*WIDTH).
REQ-003 SHALL have parameter STRIDE, default 2, tap index step (>=1).
REQ-004 SHALL have parameter FRAME_LEN, default 4, output beats per frame (>=2).
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, input beat offered.
REQ-008 SHALL have port in_ready, output, 1, input beat accepted when in_valid and in_ready are both high.
REQ-009 SHALL have ports a and b, input, WIDTH each, operand vectors.
REQ-010 SHALL have port out_valid, output, 1, out_y valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.
REQ-012 SHALL have port out_y, output, WIDTH, per-lane parity result.
REQ-013 SHALL have port out_last, output, 1, final beat of a frame.
REQ-014 SHALL have port out_acc, output, WIDTH, frame XOR checksum; valid when out_last is high.

Function
REQ-015 SHALL form a mix vector m[2*WIDTH-1:0] for each lane i: even i gives m[i]=a[i]&b[i] and m[i+WIDTH]=a[i]|b[i]; odd i gives m[i]=a[i]|b[i] and m[i+WIDTH]=a[i]&b[i].
REQ-016 SHALL compute y[i] = XOR over j=0..TAPS-1 of m[(i+STRIDE*j) mod (2*WIDTH)]; the index wraps and never goes out of range.
REQ-017 SHALL register m and a valid bit in stage 1, and y and out_valid in stage 2; latency is 2 clk from accepted beat to out_valid, with no stalls.
REQ-018 SHALL advance the pipe when adv = !out_valid || out_ready; in_ready = adv (global stall); a stage-1 bubble propagates as invalid.
REQ-019 SHALL hold out_y, out_last and out_acc stable while out_valid && !out_ready.
REQ-020 SHALL transfer an output beat on out_valid && out_ready; a beat count increments on each transfer and wraps from FRAME_LEN-1 to 0.
REQ-021 SHALL drive out_last high while out_valid and the beat count equals FRAME_LEN-1.
REQ-022 SHALL have out_acc = running XOR of earlier transferred y in the current frame, XOR the current out_y; the running XOR clears to 0 on the last-beat transfer.
REQ-023 SHALL handle a transfer and a new acceptance in the same cycle with no lost or duplicated beat.

Reset
REQ-024 SHALL, on rst high at a clk edge, clear both stage valids, out_y, the running XOR and the beat count to 0, discarding in-flight beats; in_ready reads 1 in the cycle after reset.
REQ-025 SHALL give rst priority over all handshake activity in the same cycle.

Configuration
REQ-026 SHALL include the beat counter, running XOR, out_last and out_acc logic when macro GEN_PARITY_FRAME_ACC_EN is defined.
REQ-027 SHALL, without GEN_PARITY_FRAME_ACC_EN, tie out_last and out_acc to 0, leave no counter or accumulator state, and keep out_y and handshake timing unchanged.

Verification (defaults unless noted; macro defined)
REQ-028 SHALL check a=8'hFF, b=8'h00 accepted at cycle 0 -> out_valid at cycle 2 with out_y=8'h99.
REQ-029 SHALL check a=b=8'hFF -> out_y=8'hFF; a=b=8'h00 -> out_y=8'h00.
REQ-030 SHALL check wrap with STRIDE=3: a=b=8'h08 -> out_y=8'hAD, lane 7 tap j=4 wrapping to index 3.
REQ-031 SHALL check a frame of outputs 8'h99, 8'hFF, 8'h00, 8'hFF -> out_last only on beat 4, out_acc=8'h99; the next frame restarts from 0.
REQ-032 SHALL check out_ready held low 5 cycles with the pipe full -> in_ready=0, out_y held, no beat lost; release gives in-order delivery.
REQ-033 SHALL check rst pulsed mid-frame with 2 beats in flight -> no output from those beats, and the next frame's out_last falls on its own 4th beat.
